// File: rtl/shapool_reporter.sv
// shapool_reporter: consumer end of the shapool result interface.
// Captures a pool success, rebuilds the true winning nonce (pipeline
// offset, unit index bits, nonce_start_MSB XOR) and streams it to the
// host transmitter as a byte frame on a valid/ready interface.
// Frame: A5, result[31:24], result[23:16], result[15:8], result[7:0],
//        match_flags [, checksum].
// Optional feature macro: SHAPOOL_REPORTER_CHECKSUM_EN appends a byte
// holding the XOR of the six preceding frame bytes.
module shapool_reporter #(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int NONCE_OFFSET   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [7:0]  i_nonce_start_MSB,
    input  logic        i_success,
    input  logic [31:0] i_nonce,
    input  logic [7:0]  i_match_flags,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_halt,
    output logic [7:0]  o_dropped
);
    localparam int L    = POOL_SIZE_LOG2;
    localparam int LO_W = 32 - L;
    localparam logic [7:0] SOF = 8'hA5;
`ifdef SHAPOOL_REPORTER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FIX, S_SEND} state_t;
    state_t r_state, w_next_state;

    // capture registers
    logic [LO_W-1:0] r_lo_in;
    logic [7:0]      r_flags;
    logic [7:0]      r_msb;
    logic [31:0]     r_result;

    // transmit side
    logic [2:0]      r_byte_idx;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_busy;
    logic            r_halt;
    logic [7:0]      r_dropped;

    logic            w_hit;
    logic            w_flags_ok;
    logic            w_capture;
    logic            w_drop;
    logic            w_xfer;
    logic            w_last;
    logic [LO_W-1:0] w_lo_raw;
    logic [LO_W-1:0] w_lo;
    logic [L-1:0]    w_idx;
    logic [31:0]     w_result;
    logic [7:0]      w_next_byte;
    logic            w_unused_nonce_hi;

    // the pool drives zeros into the top L nonce bits; they carry nothing
    assign w_unused_nonce_hi = ^i_nonce[31:LO_W];

    assign w_hit      = i_enable & i_success;
    assign w_flags_ok = |i_match_flags[POOL_SIZE-1:0];
    assign w_capture  = w_hit & w_flags_ok & (r_state == S_IDLE);
    // a success that cannot be reported: flagless, or arriving mid-frame
    assign w_drop     = w_hit & (~w_flags_ok | (r_state != S_IDLE));
    assign w_xfer     = r_tx_valid & i_tx_ready;
    assign w_last     = (r_byte_idx == LAST_IDX);

    // counter has run NONCE_OFFSET past the match; undo it (wraps mod 2^LO_W)
    assign w_lo_raw = r_lo_in - LO_W'(NONCE_OFFSET);
    assign w_lo     = {w_lo_raw[LO_W-1 -: 8] ^ r_msb, w_lo_raw[LO_W-9:0]};
    assign w_result = {w_idx, w_lo};

    // index of the lowest matching pipeline (priority to bit 0)
    always_comb begin
        w_idx = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (r_flags[i]) w_idx = L'(i);
        end
    end

`ifdef SHAPOOL_REPORTER_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = SOF ^ r_result[31:24] ^ r_result[23:16]
                  ^ r_result[15:8] ^ r_result[7:0] ^ r_flags;
`endif

    // byte that follows the one currently presented
    always_comb begin
        w_next_byte = 8'h00;
        case (r_byte_idx)
            3'd0: w_next_byte = r_result[31:24];
            3'd1: w_next_byte = r_result[23:16];
            3'd2: w_next_byte = r_result[15:8];
            3'd3: w_next_byte = r_result[7:0];
            3'd4: w_next_byte = r_flags;
`ifdef SHAPOOL_REPORTER_CHECKSUM_EN
            3'd5: w_next_byte = w_csum;
`endif
            default: w_next_byte = 8'h00;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next_state;
    end

    // next-state logic: IDLE -> FIX (one cycle) -> SEND -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_SEND;
            S_SEND:  if (w_xfer && w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // capture, nonce fix-up and byte sequencing
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lo_in    <= '0;
            r_flags    <= '0;
            r_msb      <= '0;
            r_result   <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_lo_in <= i_nonce[LO_W-1:0];
                        r_flags <= i_match_flags;
                        r_msb   <= i_nonce_start_MSB;
                        r_busy  <= 1'b1;
                        r_halt  <= 1'b1;
                    end
                end
                S_FIX: begin
                    r_result   <= w_result;
                    r_byte_idx <= '0;
                    r_tx_data  <= SOF;
                    r_tx_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_halt     <= 1'b0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx_data  <= w_next_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // saturating lost-result counter, cleared only by reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                        r_dropped <= '0;
        else if (w_drop && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_halt     = r_halt;
    assign o_dropped  = r_dropped;

endmodule

// File: tb/tb_shapool_reporter.sv
// Directed bench for shapool_reporter (POOL_SIZE=2, NONCE_OFFSET=2).
module tb_shapool_reporter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        success = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  msb = 8'h00;
    logic [7:0]  flags = 8'h00;
    logic [31:0] nonce = 32'h0;
    logic [7:0]  tx_data;
    logic [7:0]  dropped;
    logic        tx_valid, busy, halt;

    int total = 0;
    int bad = 0;

`ifdef SHAPOOL_REPORTER_CHECKSUM_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic [7:0] rx [0:6];
    logic [7:0] exp_b [0:6];
    int         rx_first;
    bit         rx_to;
    bit         rx_hold_bad;

    always #5 clk = ~clk;

    shapool_reporter #(.POOL_SIZE(2), .POOL_SIZE_LOG2(1), .NONCE_OFFSET(2)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable),
        .i_nonce_start_MSB(msb), .i_success(success), .i_nonce(nonce),
        .i_match_flags(flags), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_busy(busy), .o_halt(halt), .o_dropped(dropped)
    );

    // one-cycle success pulse; called and returns at a negedge
    task automatic pulse(input logic [7:0] m, input logic [31:0] n, input logic [7:0] f);
        msb = m; nonce = n; flags = f; success = 1'b1;
        @(posedge clk); @(negedge clk);
        success = 1'b0;
    endtask

    // receive one frame into rx[]; optional stall of stall_n cycles on byte
    // stall_at, optional success pulses (bit k of pmask = pulse in cycle k)
    task automatic collect(input int stall_at, input int stall_n, input logic [31:0] pmask);
        int n = 0;
        int cyc = 0;
        int stalls = 0;
        logic [7:0] held = 8'h00;
        rx_to = 1'b0; rx_hold_bad = 1'b0; rx_first = -1;
        for (int k = 0; k < 7; k++) rx[k] = 8'h00;
        while (n < FLEN) begin
            if (cyc > 100) begin
                rx_to = 1'b1;
                break;
            end
            success = (cyc < 32) ? pmask[cyc] : 1'b0;
            if (tx_valid && rx_first < 0) rx_first = cyc;
            if (tx_valid && !halt) rx_hold_bad = 1'b1;
            if (tx_valid) begin
                if (n == stall_at && stalls < stall_n) begin
                    if (stalls == 0) held = tx_data;
                    else if (tx_data !== held) rx_hold_bad = 1'b1;
                    tx_ready = 1'b0;
                    stalls++;
                end else begin
                    tx_ready = 1'b1;
                    rx[n] = tx_data;
                    n++;
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        success = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || halt !== 1'b0) begin
            bad++; $display("FAIL reset_ctl got v=%b b=%b h=%b exp 0 0 0", tx_valid, busy, halt); end
        total++; if (tx_data !== 8'h00 || dropped !== 8'h00) begin
            bad++; $display("FAIL reset_data got d=%h dr=%h exp 00 00", tx_data, dropped); end
        @(negedge clk); reset_n = 1'b1; enable = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || dropped !== 8'h00) begin
            bad++; $display("FAIL idle_after_reset got v=%b b=%b dr=%h", tx_valid, busy, dropped); end
    endtask

    task automatic test_basic();
        exp_b = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h03, 8'h02, 8'h24};
        pulse(8'h00, 32'h0000_0005, 8'h02);
        total++; if (busy !== 1'b1 || halt !== 1'b1 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL fix_cycle got b=%b h=%b v=%b exp 1 1 0", busy, halt, tx_valid); end
        collect(99, 0, 32'h0);
        total++; if (rx_to) begin bad++; $display("FAIL basic_timeout got timeout exp frame"); end
        total++; if (rx_first !== 1) begin
            bad++; $display("FAIL basic_latency got %0d exp 1", rx_first); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL basic_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || halt !== 1'b0) begin
            bad++; $display("FAIL basic_end got v=%b b=%b h=%b exp 0 0 0", tx_valid, busy, halt); end
    endtask

    task automatic test_xor_msb();
        exp_b = '{8'hA5, 8'h09, 8'h00, 8'h01, 8'h00, 8'h01, 8'hAC};
        pulse(8'h12, 32'h0000_0102, 8'h01);
        collect(99, 0, 32'h0);
        total++; if (rx_to) begin bad++; $display("FAIL xor_timeout got timeout exp frame"); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL xor_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
    endtask

    task automatic test_wrap_enable_drop();
        exp_b = '{8'hA5, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h24};
        pulse(8'h00, 32'h0000_0001, 8'h01);
        enable = 1'b0;
        collect(99, 0, 32'h0);
        total++; if (rx_to) begin bad++; $display("FAIL wrap_timeout got timeout exp frame"); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL wrap_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
        enable = 1'b1;
    endtask

    task automatic test_backpressure();
        exp_b = '{8'hA5, 8'h09, 8'h00, 8'h01, 8'h00, 8'h01, 8'hAC};
        pulse(8'h12, 32'h0000_0102, 8'h01);
        collect(2, 5, 32'h0);
        total++; if (rx_to) begin bad++; $display("FAIL bp_timeout got timeout exp frame"); end
        total++; if (rx_hold_bad) begin
            bad++; $display("FAIL bp_hold got unstable data/halt exp stable"); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL bp_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
        total++; if (busy !== 1'b0 || halt !== 1'b0 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end got b=%b h=%b v=%b exp 0 0 0", busy, halt, tx_valid); end
    endtask

    task automatic test_drops();
        exp_b = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h03, 8'h02, 8'h24};
        pulse(8'h00, 32'h0000_0005, 8'h02);
        msb = 8'hFF; nonce = 32'hDEAD_BEEF; flags = 8'h03;
        collect(99, 0, 32'h0000_001C);
        total++; if (rx_to) begin bad++; $display("FAIL drop_timeout got timeout exp frame"); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL drop_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
        total++; if (dropped !== 8'd3) begin
            bad++; $display("FAIL drop_busy got %0d exp 3", dropped); end
        pulse(8'h00, 32'h0000_0005, 8'h00);
        total++; if (dropped !== 8'd4 || busy !== 1'b0) begin
            bad++; $display("FAIL drop_noflag got dr=%0d b=%b exp 4 0", dropped, busy); end
        enable = 1'b0;
        pulse(8'h00, 32'h0000_0005, 8'h02);
        for (int c = 0; c < 4; c++) begin
            total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL enable_low_c%0d got v=%b b=%b exp 0 0", c, tx_valid, busy); end
            @(negedge clk);
        end
        total++; if (dropped !== 8'd4) begin
            bad++; $display("FAIL enable_low_drop got %0d exp 4", dropped); end
        enable = 1'b1;
    endtask

    task automatic test_saturate();
        flags = 8'h00; success = 1'b1;
        repeat (260) @(negedge clk);
        success = 1'b0;
        @(negedge clk);
        total++; if (dropped !== 8'hFF || tx_valid !== 1'b0) begin
            bad++; $display("FAIL saturate got dr=%h v=%b exp ff 0", dropped, tx_valid); end
    endtask

    task automatic test_async_reset();
        pulse(8'h00, 32'h0000_0005, 8'h02);
        repeat (3) @(negedge clk);
        total++; if (tx_valid !== 1'b1 || halt !== 1'b1) begin
            bad++; $display("FAIL midframe_pre got v=%b h=%b exp 1 1", tx_valid, halt); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || halt !== 1'b0 || dropped !== 8'h00) begin
            bad++; $display("FAIL async_reset got v=%b b=%b h=%b dr=%h exp 0 0 0 00",
                            tx_valid, busy, halt, dropped); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        exp_b = '{8'hA5, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h24};
        pulse(8'h00, 32'h0000_0001, 8'h01);
        collect(99, 0, 32'h0);
        total++; if (rx_to) begin bad++; $display("FAIL post_reset_timeout got timeout exp frame"); end
        for (int k = 0; k < FLEN; k++) begin
            total++; if (rx[k] !== exp_b[k]) begin
                bad++; $display("FAIL post_reset_byte%0d got %h exp %h", k, rx[k], exp_b[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_xor_msb();
        test_wrap_enable_drop();
        test_backpressure();
        test_drops();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shapool_reporter.md
Name: shapool_reporter

Overview:
- Consumer end of the shapool result interface.
- Samples the pool's success, nonce and match_flags outputs and reconstructs the true winning nonce, undoing the pipeline offset, the unit index bits and the nonce_start_MSB XOR.
- Emits the result as a byte frame on a valid/ready stream toward the host transmitter (SPI/UART tx).
- Drives halt so the top-level controller can freeze the pool while the result is reported.

Parameters:
- POOL_SIZE, 2, number of hashing pipelines in the attached pool; power of 2, at most 8.
- POOL_SIZE_LOG2, 1, log2(POOL_SIZE); must be greater than 0. L below denotes this value.
- NONCE_OFFSET, 2, nonce increments between the matching hash and the success pulse.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  arms capture; success is ignored while low.
- nonce_start_MSB  in  8  same job value that is fed to the pool.
- success  in  1  pool success pulse.
- nonce  in  32  pool nonce output, {L zeros, lower counter}.
- match_flags  in  8  pool per-pipeline match bits.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte.
- busy  out  1  frame capture or transmission in progress.
- halt  out  1  request to hold the pool in reset.
- dropped  out  8  saturating count of lost or invalid results.

Behaviour:
- Reset values (asynchronous): tx_data=0, tx_valid=0, busy=0, halt=0, dropped=0, state IDLE, all capture registers 0.
- State machine: IDLE -> FIX -> SEND -> IDLE.
- IDLE:
  - On a posedge with enable=1 and success=1, register nonce, match_flags and nonce_start_MSB.
  - If match_flags[POOL_SIZE-1:0]==0, do not capture; increment dropped and stay in IDLE.
  - Otherwise go to FIX. busy and halt assert from the next cycle.
  - While enable=0, success is ignored and not counted.
- FIX (exactly 1 cycle) computes the corrected nonce:
  - lo = (nonce[31-L:0] - NONCE_OFFSET) mod 2^(32-L). This wraps.
  - lo[31-L:24-L] is XORed with the captured nonce_start_MSB.
  - idx = index of the lowest set bit of match_flags[POOL_SIZE-1:0].
  - result = {idx[L-1:0], lo}.
- SEND: bytes go out in this order:
  - 0xA5
  - result[31:24], result[23:16], result[15:8], result[7:0]
  - captured match_flags
  - checksum (optional feature only)
- Handshake:
  - tx_valid rises on the first cycle of SEND.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on a posedge with tx_valid and tx_ready both 1; the next byte is presented the following cycle with no bubble.
  - After the last byte transfers: tx_valid=0, busy=0 and halt=0 in the next cycle, state IDLE.
- Latency: success sampled at edge T gives first tx_valid at T+2.
- success=1 while busy (FIX or SEND): the frame is unaffected; dropped increments and saturates at 255.
- enable falling mid-frame: the frame completes normally.
- Asynchronous reset mid-frame: outputs return to reset values immediately; the partial frame is abandoned.
- dropped clears only on reset.

Optional Feature:
- Macro: SHAPOOL_REPORTER_CHECKSUM_EN.
- Defined: the frame is 7 bytes; the last byte is the XOR of the 6 preceding bytes.
- Undefined: the frame is 6 bytes ending with match_flags; no checksum logic is built.

Test Plan:
1. POOL_SIZE=2, checksum on, nonce_start_MSB=0x00, nonce=0x00000005, match_flags=0x02, tx_ready=1 -> bytes A5 80 00 00 03 02 24 on consecutive cycles; first tx_valid 2 cycles after the success edge.
2. nonce_start_MSB=0x12, nonce=0x00000102, match_flags=0x01 -> result 0x09000100; bytes A5 09 00 01 00 01, checksum 0xAC.
3. Wrap case: nonce=0x00000001, match_flags=0x01, MSB=0x00 -> result 0x7FFFFFFF.
4. Backpressure: hold tx_ready=0 for 5 cycles on byte 3 -> tx_data stays 0x00 and tx_valid stays 1; halt stays 1 until the final byte transfers; busy/halt drop the cycle after.
5. Three success pulses during SEND, plus one in IDLE with match_flags=0x00 -> dropped=4; frame content unchanged; enable=0 with a success pulse -> dropped unchanged, no frame.
6. Assert reset_n=0 mid-SEND without a clock edge -> tx_valid, busy and halt go to 0 immediately; after release, a new success produces a full, correct frame.
